// File: rtl/shift_reg_pkg.sv
// Shared mode/state encodings and mode classification helpers for the universal shift register.
// UNIV_SHIFT_REG_ROTATE_EN enables the rotate modes; otherwise they behave as hold.
package shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHR   = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_ROL   = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_HOLD2 = 3'b111
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Modes whose new MSB comes from a fill bit and the rest moves down.
    function automatic logic is_right(mode_t m);
        case (m)
            MODE_SHR,
            MODE_ASR: return 1'b1;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            MODE_ROR: return 1'b1;
`endif
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic is_left(mode_t m);
        case (m)
            MODE_SHL: return 1'b1;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            MODE_ROL: return 1'b1;
`endif
            default:  return 1'b0;
        endcase
    endfunction

    // Only genuine shift-class modes may launch a burst.
    function automatic logic is_burst_mode(mode_t m);
        return is_right(m) | is_left(m);
    endfunction

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst sequencer: IDLE/RUN/DONE FSM with shift counter; tells the datapath when to step.
// Burst eligibility follows UNIV_SHIFT_REG_ROTATE_EN through the package helpers.
module shift_burst_ctrl
    import shift_reg_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic             step,
    output logic             single,
    output logic [2:0]       run_mode
);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       run_mode_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             in_idle;
    logic             accept;

    assign in_idle = (state_reg == ST_IDLE);
    assign accept  = in_idle & en & start & is_burst_mode(mode_t'(mode));
    assign single  = in_idle & en & ~accept;
    assign step    = (state_reg == ST_RUN) & en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            run_mode_reg <= MODE_HOLD;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        run_mode_reg <= mode;
                        if (amount == '0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            cnt_reg   <= amount;
                            state_reg <= ST_RUN;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                        if (cnt_reg == CNT_W'(1)) begin
                            state_reg <= ST_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // done is a single-cycle pulse regardless of en
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign run_mode = run_mode_reg;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/shift/load/rotate/arith-shift, single-step or counted burst.
// Define UNIV_SHIFT_REG_ROTATE_EN to enable rotate modes 100/101.
module univ_shift_reg
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             step;
    logic             single;
    logic [2:0]       run_mode;
    mode_t            op_mode;
    logic             op_right;
    logic             op_left;
    logic             op_load;
    logic             msb_fill;
    logic             lsb_fill;

    shift_burst_ctrl #(
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .start    (start),
        .mode     (mode),
        .amount   (amount),
        .busy     (busy),
        .done     (done),
        .step     (step),
        .single   (single),
        .run_mode (run_mode)
    );

    // During a burst the latched mode drives the datapath; live mode is ignored.
    assign op_mode  = step ? mode_t'(run_mode) : mode_t'(mode);
    assign op_right = is_right(op_mode);
    assign op_left  = is_left(op_mode);
    assign op_load  = (op_mode == MODE_LOAD);

    always_comb begin
        msb_fill = sin_r;
        case (op_mode)
            MODE_ASR: msb_fill = q_reg[WIDTH-1];
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            MODE_ROR: msb_fill = q_reg[0];
`endif
            default:  msb_fill = sin_r;
        endcase
    end

    always_comb begin
        lsb_fill = sin_l;
        case (op_mode)
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            MODE_ROL: lsb_fill = q_reg[WIDTH-1];
`endif
            default:  lsb_fill = sin_l;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic upper;
            logic lower;
            if (gi == WIDTH - 1) begin : g_up_edge
                assign upper = msb_fill;
            end else begin : g_up_mid
                assign upper = q_reg[gi+1];
            end
            if (gi == 0) begin : g_lo_edge
                assign lower = lsb_fill;
            end else begin : g_lo_mid
                assign lower = q_reg[gi-1];
            end
            assign q_next[gi] = op_load  ? din[gi] :
                                op_right ? upper   :
                                op_left  ? lower   :
                                           q_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (step | single) begin
            q_reg <= q_next;
        end
    end

    assign q      = q_reg;
    assign sout_r = q_reg[0];
    assign sout_l = q_reg[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8); rotate burst runs only
// when UNIV_SHIFT_REG_ROTATE_EN is defined, otherwise the rotate-as-hold case runs.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [7:0] din = 8'h00;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
    logic       start = 1'b0;
    logic [3:0] amount = 4'd0;
    logic [7:0] q;
    logic       sout_r;
    logic       sout_l;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode),
        .din    (din),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .start  (start),
        .amount (amount),
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", tag, got, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        check({tag, ".q"}, {24'd0, q}, {24'd0, eq});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
        check({tag, ".done"}, {31'd0, done}, {31'd0, ed});
    endtask

    initial begin
        // reset from a known-high level so the async clear sees a real falling edge
        #1 rst_n = 1'b0;
        #2 check_st("reset", 8'h00, 1'b0, 1'b0);
        #9 rst_n = 1'b1;

        // single-step operations
        en = 1'b1; mode = 3'b011; din = 8'hA5;
        tick(); check("load_a5", {24'd0, q}, 32'hA5);
        check("sout_r_a5", {31'd0, sout_r}, 32'd1);
        mode = 3'b001; sin_r = 1'b1;
        tick(); check("shr_d2", {24'd0, q}, 32'hD2);
        check("sout_r_d2", {31'd0, sout_r}, 32'd0);
        mode = 3'b010; sin_l = 1'b0;
        tick(); check("shl_a4", {24'd0, q}, 32'hA4);
        check("sout_l_a4", {31'd0, sout_l}, 32'd1);
        en = 1'b0; mode = 3'b001;
        tick(); check("en0_hold", {24'd0, q}, 32'hA4);
        en = 1'b1; mode = 3'b011; din = 8'h96;
        tick(); check("load_96", {24'd0, q}, 32'h96);
        mode = 3'b110;
        tick(); check("asr_cb", {24'd0, q}, 32'hCB);
        mode = 3'b111;
        tick(); check("hold7", {24'd0, q}, 32'hCB);

        // start ignored for hold/load modes
        mode = 3'b000; start = 1'b1; amount = 4'd3;
        tick(); check_st("start_hold", 8'hCB, 1'b0, 1'b0);
        mode = 3'b011; din = 8'h81;
        tick(); check_st("start_load", 8'h81, 1'b0, 1'b0);

`ifndef UNIV_SHIFT_REG_ROTATE_EN
        mode = 3'b100;
        tick(); check_st("ror_off_a", 8'h81, 1'b0, 1'b0);
        tick(); check_st("ror_off_b", 8'h81, 1'b0, 1'b0);
`endif

        // zero-length burst
        mode = 3'b001; amount = 4'd0;
        tick(); check_st("amt0", 8'h81, 1'b0, 1'b1);
        start = 1'b0; mode = 3'b000;
        tick(); check_st("amt0_end", 8'h81, 1'b0, 1'b0);

        // shift-left burst of 3; mode/din/start changes during RUN/DONE are ignored
        mode = 3'b010; sin_l = 1'b1; start = 1'b1; amount = 4'd3;
        tick(); check_st("shl3_go", 8'h81, 1'b1, 1'b0);
        mode = 3'b011; din = 8'hFF; amount = 4'd7;
        tick(); check_st("shl3_1", 8'h03, 1'b1, 1'b0);
        tick(); check_st("shl3_2", 8'h07, 1'b1, 1'b0);
        tick(); check_st("shl3_3", 8'h0F, 1'b0, 1'b1);
        start = 1'b0; mode = 3'b000;
        tick(); check_st("shl3_idle", 8'h0F, 1'b0, 1'b0);

        // shift-right burst of 2 with one stalled cycle
        mode = 3'b001; sin_r = 1'b0; start = 1'b1; amount = 4'd2;
        tick(); check_st("shr2_go", 8'h0F, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b000; en = 1'b0;
        tick(); check_st("shr2_stall", 8'h0F, 1'b1, 1'b0);
        en = 1'b1;
        tick(); check_st("shr2_1", 8'h07, 1'b1, 1'b0);
        tick(); check_st("shr2_2", 8'h03, 1'b0, 1'b1);
        tick(); check_st("shr2_idle", 8'h03, 1'b0, 1'b0);

`ifdef UNIV_SHIFT_REG_ROTATE_EN
        mode = 3'b011; din = 8'h81;
        tick(); check("rol_load", {24'd0, q}, 32'h81);
        mode = 3'b101; start = 1'b1; amount = 4'd3;
        tick(); check_st("rol3_go", 8'h81, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b000;
        tick(); check_st("rol3_1", 8'h03, 1'b1, 1'b0);
        en = 1'b0;
        tick(); check_st("rol3_stall", 8'h03, 1'b1, 1'b0);
        en = 1'b1;
        tick(); check_st("rol3_2", 8'h06, 1'b1, 1'b0);
        tick(); check_st("rol3_3", 8'h0C, 1'b0, 1'b1);
        tick(); check_st("rol3_idle", 8'h0C, 1'b0, 1'b0);
`endif

        // reset in the middle of a 5-shift burst
        mode = 3'b010; sin_l = 1'b0; start = 1'b1; amount = 4'd5;
        tick(); check_st("rst_go", q, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b000;
        tick();
        tick(); check("rst_pre_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_st("rst_mid", 8'h00, 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); check_st($sformatf("post_rst_%0d", i), 8'h00, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
